// File: rtl/fa_ripple_pkg.sv
// Shared constants and bit-level full-adder functions for the ripple adder.
package fa_ripple_pkg;

  // Widest operand the ripple adder is intended to be built at.
  localparam int FA_MAX_WIDTH = 64;

  // Sum bit of a full adder: odd parity of the three inputs.
  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  // Carry bit of a full adder: majority of the three inputs.
  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder; one link of the ripple carry chain.
module fa_cell
  import fa_ripple_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = fa_sum(a, b, ci);
  assign co = fa_carry(a, b, ci);

endmodule

// File: rtl/fa_ripple_reg.sv
// Registered WIDTH-bit ripple-carry adder with a valid strobe.
// Optional feature macro: FA_RIPPLE_OVF_EN adds a registered signed-overflow
// output 'ovf'; with the macro undefined the port and its logic are absent.
// Results appear one cycle after in_valid; sum/cout hold when in_valid is low,
// so operand values driven during idle cycles never reach the outputs.
module fa_ripple_reg
  import fa_ripple_pkg::*;
#(
  parameter int WIDTH = 1   // legal range 1..FA_MAX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
`ifdef FA_RIPPLE_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry out.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  assign w_carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      fa_cell u_cell (
        .a  (a[gi]),
        .b  (b[gi]),
        .ci (w_carry[gi]),
        .s  (w_sum[gi]),
        .co (w_carry[gi+1])
      );
    end
  endgenerate

  // Valid strobe follows in_valid with one cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
    end
  end

  // Capture sum and carry-out only for valid operands; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (in_valid) begin
      r_sum  <= w_sum;
      r_cout <= w_carry[WIDTH];
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;

`ifdef FA_RIPPLE_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_fa_ripple_reg.sv
// Directed and randomised checks of fa_ripple_reg at WIDTH = 1, 8 and 16.
// Build with FA_RIPPLE_OVF_EN defined to also exercise the ovf output.
module tb_fa_ripple_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH = 1 instance
  logic       v1, a1, b1, c1;
  logic       ov1, co1;
  logic [0:0] s1;
  // WIDTH = 8 instance
  logic       v8, c8;
  logic [7:0] a8, b8;
  logic       ov8, co8;
  logic [7:0] s8;
  // WIDTH = 16 instance
  logic        v16, c16;
  logic [15:0] a16, b16;
  logic        ov16, co16;
  logic [15:0] s16;
`ifdef FA_RIPPLE_OVF_EN
  logic ovf1, ovf8, ovf16;
`endif

  fa_ripple_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .sum(s1),
`ifdef FA_RIPPLE_OVF_EN
    .cout(co1), .ovf(ovf1)
`else
    .cout(co1)
`endif
  );

  fa_ripple_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
    .out_valid(ov8), .sum(s8),
`ifdef FA_RIPPLE_OVF_EN
    .cout(co8), .ovf(ovf8)
`else
    .cout(co8)
`endif
  );

  fa_ripple_reg #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
    .out_valid(ov16), .sum(s16),
`ifdef FA_RIPPLE_OVF_EN
    .cout(co16), .ovf(ovf16)
`else
    .cout(co16)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  exp_s1_tbl;
  logic [7:0]  exp_c1_tbl;
  logic [16:0] exp17;

  initial begin
    // Truth table of the full adder, indexed by {a,b,cin}.
    exp_s1_tbl = 8'b1001_0110;
    exp_c1_tbl = 8'b1110_1000;

    rst = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; c1 = 0;
    v8 = 0; a8 = 0; b8 = 0; c8 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0;

    #1 rst = 1'b1;
    #1;
    check("rst_w1_valid", 64'(ov1), 64'd0);
    check("rst_w8_sum", 64'(s8), 64'd0);
    check("rst_w8_cout", 64'(co8), 64'd0);
    check("rst_w16_valid", 64'(ov16), 64'd0);
`ifdef FA_RIPPLE_OVF_EN
    check("rst_w8_ovf", 64'(ovf8), 64'd0);
`endif

    @(negedge clk);
    rst = 1'b0;

    // Single directed vector, then the full WIDTH=1 truth table.
    v1 = 1; a1 = 1; b1 = 0; c1 = 1;
    tick();
    check("w1_101_sum", 64'(s1), 64'd0);
    check("w1_101_cout", 64'(co1), 64'd1);
    check("w1_101_valid", 64'(ov1), 64'd1);

    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = i[2:0];
      v1 = 1;
      tick();
      check($sformatf("w1_sweep%0d_sum", i), 64'(s1), 64'(exp_s1_tbl[i]));
      check($sformatf("w1_sweep%0d_cout", i), 64'(co1), 64'(exp_c1_tbl[i]));
    end
    v1 = 0;
    tick();
    check("w1_idle_valid", 64'(ov1), 64'd0);

    // WIDTH=8 boundaries.
    v8 = 1; a8 = 8'hFF; b8 = 8'h00; c8 = 1;
    tick();
    check("w8_wrap_sum", 64'(s8), 64'h00);
    check("w8_wrap_cout", 64'(co8), 64'd1);
`ifdef FA_RIPPLE_OVF_EN
    check("w8_wrap_ovf", 64'(ovf8), 64'd0);
`endif
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1;
    tick();
    check("w8_ones_sum", 64'(s8), 64'hFF);
    check("w8_ones_cout", 64'(co8), 64'd1);
    a8 = 8'h7F; b8 = 8'h01; c8 = 0;
    tick();
    check("w8_7f01_sum", 64'(s8), 64'h80);
    check("w8_7f01_cout", 64'(co8), 64'd0);
`ifdef FA_RIPPLE_OVF_EN
    check("w8_7f01_ovf", 64'(ovf8), 64'd1);
`endif
    a8 = 8'h55; b8 = 8'hAA; c8 = 0;
    tick();
    check("w8_55aa_sum", 64'(s8), 64'hFF);
    check("w8_55aa_cout", 64'(co8), 64'd0);

    // Hold behaviour: X operands while idle must not disturb the result.
    a8 = 8'd3; b8 = 8'd4; c8 = 0;
    tick();
    check("w8_hold_load", 64'(s8), 64'd7);
    v8 = 0; a8 = 'x; b8 = 'x; c8 = 1'bx;
    tick();
    check("w8_hold_valid", 64'(ov8), 64'd0);
    check("w8_hold_sum", 64'(s8), 64'd7);
    check("w8_hold_cout", 64'(co8), 64'd0);
    tick();
    check("w8_hold2_sum", 64'(s8), 64'd7);
    a8 = 0; b8 = 0; c8 = 0;

    // Random WIDTH=16 operands plus the wrap boundary.
    for (int i = 0; i < 20; i++) begin
      if (i == 0) begin
        a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1;
      end else begin
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        c16 = 1'($urandom_range(0, 1));
      end
      v16 = 1;
      exp17 = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
      tick();
      check($sformatf("w16_rnd%0d_sum", i), 64'(s16), 64'(exp17[15:0]));
      check($sformatf("w16_rnd%0d_cout", i), 64'(co16), 64'(exp17[16]));
    end

    // Asynchronous reset between edges while a result is valid.
    a16 = 16'd3; b16 = 16'd5; c16 = 0; v16 = 1;
    tick();
    check("w16_pre_rst_sum", 64'(s16), 64'd8);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(ov16), 64'd0);
    check("async_rst_sum", 64'(s16), 64'd0);
    check("async_rst_w8_sum", 64'(s8), 64'd0);
    a16 = 16'd9; b16 = 16'd1; c16 = 1;
    tick();
    check("rst_held_valid", 64'(ov16), 64'd0);
    check("rst_held_sum", 64'(s16), 64'd0);

    // The first edge after release samples normally.
    @(negedge clk);
    rst = 1'b0;
    a16 = 16'd10; b16 = 16'd20; c16 = 1;
    tick();
    check("post_rst_valid", 64'(ov16), 64'd1);
    check("post_rst_sum", 64'(s16), 64'd31);
    v16 = 0;
    tick();
    check("post_rst_idle", 64'(ov16), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
